// File: rtl/edgegen_pkg.sv
// rtl/edgegen_pkg.sv - shared state encoding and sizing helper for the edge level generator
package edgegen_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_HOLD_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_HOLD_LOW  = 2'd3
   } state_t;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down counter that saturates at zero
module dwell_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // A load wins over counting so a new dwell restarts cleanly on the transition edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/edge_level_gen.sv
// rtl/edge_level_gen.sv - rebuilds a level from rise/fall request pulses with minimum dwell times
module edge_level_gen
   import edgegen_pkg::*;
#(
   parameter int MIN_HIGH = 4,
   parameter int MIN_LOW  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic rise_req,
   input  logic fall_req,
   output logic level,
   output logic rise_ack,
   output logic fall_ack,
   output logic req_drop,
   output logic busy
);

   localparam int CNT_W = $clog2(max(MIN_HIGH, MIN_LOW)) + 1;
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

   state_t state, state_nx;
   logic   pend_rise, pend_rise_nx;
   logic   pend_fall, pend_fall_nx;
   logic   do_rise, do_fall, drop_nx;
   logic   cnt_zero;
   logic   cnt_load, cnt_en;
   logic [CNT_W-1:0] cnt_load_val;

   always_comb begin
      state_nx     = state;
      pend_rise_nx = pend_rise;
      pend_fall_nx = pend_fall;
      do_rise      = 1'b0;
      do_fall      = 1'b0;
      drop_nx      = 1'b0;

      case (state)
         S_LOW: begin
            do_rise = rise_req;
            drop_nx = fall_req;
         end
         S_HOLD_HIGH: begin
            drop_nx = rise_req;
            if (cnt_zero) begin
               // A live request at the expiry edge is honoured now, not deferred.
               if (pend_fall || fall_req) begin
                  do_fall = 1'b1;
                  if (pend_fall && fall_req) drop_nx = 1'b1;
               end else begin
                  state_nx = S_HIGH;
               end
            end else if (fall_req) begin
               if (pend_fall) drop_nx = 1'b1;
               else           pend_fall_nx = 1'b1;
            end
         end
         S_HIGH: begin
            do_fall = fall_req;
            drop_nx = rise_req;
         end
         S_HOLD_LOW: begin
            drop_nx = fall_req;
            if (cnt_zero) begin
               if (pend_rise || rise_req) begin
                  do_rise = 1'b1;
                  if (pend_rise && rise_req) drop_nx = 1'b1;
               end else begin
                  state_nx = S_LOW;
               end
            end else if (rise_req) begin
               if (pend_rise) drop_nx = 1'b1;
               else           pend_rise_nx = 1'b1;
            end
         end
         default: state_nx = S_LOW;
      endcase

      if (do_rise) begin
         state_nx     = S_HOLD_HIGH;
         pend_rise_nx = 1'b0;
      end
      if (do_fall) begin
         state_nx     = S_HOLD_LOW;
         pend_fall_nx = 1'b0;
      end
   end

   assign cnt_load     = do_rise || do_fall;
   assign cnt_load_val = do_rise ? HIGH_LOAD : LOW_LOAD;
   assign cnt_en       = (state == S_HOLD_HIGH) || (state == S_HOLD_LOW);

   dwell_counter #(
      .CNT_W(CNT_W)
   ) u_dwell_counter (
      .clk     (clk),
      .reset   (reset),
      .load    (cnt_load),
      .load_val(cnt_load_val),
      .en      (cnt_en),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOW;
         pend_rise <= 1'b0;
         pend_fall <= 1'b0;
         level     <= 1'b0;
         rise_ack  <= 1'b0;
         fall_ack  <= 1'b0;
         req_drop  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         pend_rise <= pend_rise_nx;
         pend_fall <= pend_fall_nx;
         if (do_rise)      level <= 1'b1;
         else if (do_fall) level <= 1'b0;
         rise_ack  <= do_rise;
         fall_ack  <= do_fall;
         req_drop  <= drop_nx;
         busy      <= (state_nx == S_HOLD_HIGH) || (state_nx == S_HOLD_LOW);
      end
   end

endmodule

// File: tb/tb_edge_level_gen.sv
// tb/tb_edge_level_gen.sv - directed self-checking bench for edge_level_gen
module tb_edge_level_gen;

   logic clk = 1'b0;
   logic reset;
   logic rise_a, fall_a, level_a, rack_a, fack_a, drop_a, busy_a;
   logic rise_b, fall_b, level_b, rack_b, fack_b, drop_b, busy_b;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   edge_level_gen #(.MIN_HIGH(4), .MIN_LOW(4)) dut_a (
      .clk(clk), .reset(reset), .rise_req(rise_a), .fall_req(fall_a),
      .level(level_a), .rise_ack(rack_a), .fall_ack(fack_a),
      .req_drop(drop_a), .busy(busy_a)
   );

   edge_level_gen #(.MIN_HIGH(1), .MIN_LOW(1)) dut_b (
      .clk(clk), .reset(reset), .rise_req(rise_b), .fall_req(fall_b),
      .level(level_b), .rise_ack(rack_b), .fall_ack(fack_b),
      .req_drop(drop_b), .busy(busy_b)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic lv, input logic ra,
                          input logic fa, input logic dr, input logic bz);
      check({tag, ".level"}, level_a, lv);
      check({tag, ".rise_ack"}, rack_a, ra);
      check({tag, ".fall_ack"}, fack_a, fa);
      check({tag, ".req_drop"}, drop_a, dr);
      check({tag, ".busy"}, busy_a, bz);
   endtask

   initial begin
      reset = 1'b1;
      rise_a = 0; fall_a = 0; rise_b = 0; fall_b = 0;
      tick(); tick();
      check_a("reset", 0, 0, 0, 0, 0);
      check("reset_b.level", level_b, 1'b0);
      reset = 1'b0;

      // Basic rise: 4 busy cycles then S_HIGH.
      rise_a = 1; tick(); rise_a = 0;
      check_a("rise_c3", 1, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_a("rise_hold", 1, 0, 0, 0, 1);
      end
      tick();
      check_a("rise_c7_high", 1, 0, 0, 0, 0);

      // Both requests in S_HIGH: fall wins, rise dropped.
      rise_a = 1; fall_a = 1; tick(); rise_a = 0; fall_a = 0;
      check_a("both_high", 0, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) tick();
      check_a("hold_low_end", 0, 0, 0, 0, 1);
      tick();
      check_a("low_idle", 0, 0, 0, 0, 0);

      // Both requests in S_LOW: rise wins, fall dropped; then pending fall.
      rise_a = 1; fall_a = 1; tick(); rise_a = 0;
      check_a("both_low", 1, 1, 0, 1, 1);
      tick(); fall_a = 0;
      check_a("pend_r1", 1, 0, 0, 0, 1);
      tick();
      check_a("pend_r2", 1, 0, 0, 0, 1);
      tick();
      check_a("pend_r3", 1, 0, 0, 0, 1);
      tick();
      check_a("pend_fall", 0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) tick();
      check_a("pend_low_idle", 0, 0, 0, 0, 0);

      // Two falls during hold-high: second dropped, one fall follows.
      rise_a = 1; tick(); rise_a = 0;
      check_a("dbl_rise", 1, 1, 0, 0, 1);
      fall_a = 1; tick();
      check_a("dbl_f1", 1, 0, 0, 0, 1);
      tick(); fall_a = 0;
      check_a("dbl_f2", 1, 0, 0, 1, 1);
      tick();
      check_a("dbl_r3", 1, 0, 0, 0, 1);
      tick();
      check_a("dbl_fall", 0, 0, 1, 0, 1);
      tick();
      check_a("dbl_after", 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick();
      check_a("dbl_idle", 0, 0, 0, 0, 0);

      // Reset in the second hold-high cycle.
      rise_a = 1; tick(); rise_a = 0;
      check_a("rst_rise", 1, 1, 0, 0, 1);
      tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check_a("rst_mid", 0, 0, 0, 0, 0);
      tick();
      rise_a = 1; tick(); rise_a = 0;
      check_a("rst_rerise", 1, 1, 0, 0, 1);

      // MIN_HIGH = MIN_LOW = 1: alternate requests every cycle.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rise_b = (i % 2 == 0);
         fall_b = (i % 2 == 1);
         tick();
         check("alt.level", level_b, (i % 2 == 0));
         check("alt.rise_ack", rack_b, (i % 2 == 0));
         check("alt.fall_ack", fack_b, (i % 2 == 1));
         check("alt.req_drop", drop_b, 1'b0);
      end
      rise_b = 0; fall_b = 0;
      tick();
      check("alt_end.level", level_b, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/edge_level_gen.md
# edge_level_gen

Dual-edge level generator: the transmit-side counterpart of the dual-edge detector. It accepts single-cycle rise/fall request pulses and reconstructs a glitch-free `level` output, enforcing programmable minimum high and low dwell times. It sits between control logic that emits edge events and a downstream consumer of the level, such as a pin driver or a detector-side loopback.

## Interface
Parameters:
- `MIN_HIGH`, default 4: minimum cycles `level` stays 1 after a rise; legal range ≥1.
- `MIN_LOW`, default 4: minimum cycles `level` stays 0 after a fall; legal range ≥1.
- `CNT_W`, localparam = `$clog2(max(MIN_HIGH,MIN_LOW))+1`: dwell counter width.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `rise_req`  in  1  request a 0→1 transition; single-cycle pulse.
- `fall_req`  in  1  request a 1→0 transition; single-cycle pulse.
- `level`  out  1  generated level; registered.
- `rise_ack`  out  1  one-cycle pulse in the first cycle `level` is 1.
- `fall_ack`  out  1  one-cycle pulse in the first cycle `level` is 0.
- `req_drop`  out  1  one-cycle pulse the cycle after an ignored request.
- `busy`  out  1  high while a dwell time is running (hold states).

## Operation
- States: `S_LOW`, `S_HOLD_HIGH`, `S_HIGH`, `S_HOLD_LOW`.
- Reset value of the state is `S_LOW`. The next state is computed combinationally; the state is registered.
- `S_LOW`:
  - On `rise_req`: set `level`=1, pulse `rise_ack`, load counter with `MIN_HIGH-1`, go to `S_HOLD_HIGH`.
  - On `fall_req`: redundant; pulse `req_drop`.
  - When both arrive together, rise is honoured and fall is dropped.
- `S_HOLD_HIGH`:
  - Counter decrements each cycle while nonzero.
  - `fall_req` sets a one-deep `pend_fall` flag. A second `fall_req` while the flag is already set is dropped.
  - `rise_req` is dropped.
  - When the counter is 0: if `pend_fall` is set or `fall_req` is present this cycle, set `level`=0, pulse `fall_ack`, load `MIN_LOW-1`, clear `pend_fall`, go to `S_HOLD_LOW`. Otherwise go to `S_HIGH`.
- `S_HIGH`:
  - On `fall_req`: fall exactly as above.
  - On `rise_req`: dropped.
  - When both arrive together, fall is honoured and rise is dropped.
- `S_HOLD_LOW` and `S_LOW` mirror `S_HOLD_HIGH` and `S_HIGH`, with `pend_rise`, `MIN_HIGH` reload, and `rise_ack`.
- `busy` = 1 exactly in the hold states; it is registered and derived from the state.
- `req_drop` pulses once per cycle in which at least one request is ignored.

## Timing
- Reset values: `level`=0, `rise_ack`=0, `fall_ack`=0, `req_drop`=0, `busy`=0, counter=0, pending flags=0.
- Latency:
  - A request sampled at edge N with no dwell active changes `level` after edge N (visible cycle N+1).
  - The ack pulse is coincident with the first cycle of the new level.
- Dwell:
  - `level` stays high for at least `MIN_HIGH` cycles and low for at least `MIN_LOW` cycles.
  - A fall pending since the rise therefore occurs exactly `MIN_HIGH` cycles after the rise.
- A request arriving in the cycle the counter reads 0 is honoured at that same edge; it is not deferred.
- Reset mid-dwell: `level` returns to 0 the next cycle and no ack pulses. Pending flags are cleared and the state becomes `S_LOW`, with no minimum-low enforced after reset.
- The pending flag for the current level direction never sets. A `pend_fall` is held only in the high-side states, and a `pend_rise` only in the low-side states.

## Structure
- A shared package `edgegen_pkg` holds:
  - the `state_t` enum (`S_LOW`, `S_HOLD_HIGH`, `S_HIGH`, `S_HOLD_LOW`);
  - a `max` helper function for `CNT_W`.
- One sub-module, `dwell_counter`:
  - inputs `load`, `load_val[CNT_W]`, `en`;
  - output `zero`;
  - down-counts and saturates at 0.
- The top module holds the FSM, the pending flags, and the output registers.

## Test plan
- Reset, then `rise_req` at cycle 2 with `MIN_HIGH`=4: `level`=1 and `rise_ack`=1 at cycle 3, `busy`=1 for cycles 3–6, state `S_HIGH` at cycle 7.
- `fall_req` one cycle after the rise, with `MIN_HIGH`=4: the fall is held pending; `level` falls exactly 4 cycles after the rise, `fall_ack` is coincident, and `req_drop` is never asserted.
- `rise_req` and `fall_req` together in `S_LOW`: `level` rises and `req_drop`=1 for one cycle. Both together in `S_HIGH`: `level` falls and `req_drop`=1.
- Two `fall_req` pulses during `S_HOLD_HIGH`: the first is held pending and the second gives `req_drop`; exactly one fall and one `fall_ack` follow.
- Assert `reset` in the second cycle of `S_HOLD_HIGH`: next cycle `level`=0, `busy`=0, no `fall_ack`. A `rise_req` two cycles later rises `level` immediately.
- `MIN_HIGH`=`MIN_LOW`=1, alternating rise/fall requests every cycle: `level` toggles every cycle with no drops.
